// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state encoding and op-class helper for the multicycle ALU
package alu_pkg;
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_SHL = 4'b0111;
   localparam logic [3:0] OP_SHR = 4'b1000;
   localparam logic [3:0] OP_ROL = 4'b1001;
   localparam logic [3:0] OP_ROR = 4'b1010;
   localparam logic [3:0] OP_ASR = 4'b1011;
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_MUL  = 2'd1;
   localparam state_t S_DIV  = 2'd2;
   localparam state_t S_DONE = 2'd3;
   function automatic logic is_iter(input logic [3:0] op);
      return op == OP_MUL || op == OP_DIV;
   endfunction
endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: WIDTH-step shift-add multiplier / restoring divider on operand magnitudes
module alu_muldiv_seq import alu_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] acc_hi, acc_lo, dvs, hi_n, lo_n, a_mag, b_mag;
   logic [WIDTH:0] sum, diff;
   logic [2*WIDTH-1:0] prod;
   logic [CW-1:0] cnt;
   logic is_div, neg_q, neg_r;
   assign a_mag = a[WIDTH-1] ? -a : a;
   assign b_mag = b[WIDTH-1] ? -b : b;
   assign done = step && cnt == CW'(WIDTH-1);
   assign prod = {hi_n, lo_n};
   assign {hi, lo} = is_div ? {neg_r ? -hi_n : hi_n, neg_q ? -lo_n : lo_n} : (neg_q ? -prod : prod);
   // next value of one iteration; outputs are taken from it so the last step lands straight in DONE
   always_comb begin
      sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : '0);
      diff = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, dvs};
      hi_n = is_div ? (diff[WIDTH] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]} : diff[WIDTH-1:0]) : sum[WIDTH:1];
      lo_n = is_div ? {acc_lo[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], acc_lo[WIDTH-1:1]};
   end
   // operand/sign capture on load, then one iteration per step
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         dvs <= '0;
         is_div <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (load) begin
         cnt <= '0;
         acc_hi <= '0;
         acc_lo <= a_mag;
         dvs <= b_mag;
         is_div <= div;
         neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
         neg_r <= a[WIDTH-1];
      end else if (step) begin
         acc_hi <= hi_n;
         acc_lo <= lo_n;
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: start/done ALU with single-cycle ops and iterative signed MUL/DIV
module alu_multicycle import alu_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             cout,
   output logic             Z,
   output logic             N,
   output logic             V,
   output logic             dz,
   output logic             err
);
   state_t state;
   logic accept, m_done, b_zero, s_cout, s_v;
   logic [WIDTH-1:0] a_r, m_lo, m_hi, q_lo, q_hi, s_res;
   logic [WIDTH:0] add_s, sub_s;
   assign accept = start && state == S_IDLE;
   assign busy = state != S_IDLE;
   assign done = state == S_DONE;
   assign add_s = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
   assign sub_s = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, ~cin};
   assign q_lo = state == S_DIV && b_zero ? '1 : m_lo;
   assign q_hi = state == S_DIV && b_zero ? a_r : m_hi;
   alu_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
      .clk(clk), .rst(rst), .load(accept && is_iter(op)), .step(state == S_MUL || state == S_DIV),
      .div(op == OP_DIV), .a(A), .b(B), .done(m_done), .lo(m_lo), .hi(m_hi)
   );
   // single-cycle datapath; illegal codes fall through to all-zero
   always_comb begin
      s_res = '0;
      s_cout = 1'b0;
      s_v = 1'b0;
      case (op)
         OP_ADD: begin
            {s_cout, s_res} = add_s;
            s_v = A[WIDTH-1] == B[WIDTH-1] && add_s[WIDTH-1] != A[WIDTH-1];
         end
         OP_SUB: begin
            {s_cout, s_res} = sub_s;
            s_v = A[WIDTH-1] != B[WIDTH-1] && sub_s[WIDTH-1] != A[WIDTH-1];
         end
         OP_AND: s_res = A & B;
         OP_OR:  s_res = A | B;
         OP_XOR: s_res = A ^ B;
         OP_SHL: {s_cout, s_res} = {A, 1'b0};
         OP_SHR: {s_res, s_cout} = {1'b0, A};
         OP_ROL: {s_cout, s_res} = {A[WIDTH-1], A[WIDTH-2:0], A[WIDTH-1]};
         OP_ROR: {s_res, s_cout} = {A[0], A};
         OP_ASR: {s_res, s_cout} = {A[WIDTH-1], A};
         default: ;
      endcase
   end
   // FSM; result and flags are loaded only on the edge that enters DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         a_r <= '0;
         b_zero <= 1'b0;
         result <= '0;
         result_hi <= '0;
         cout <= 1'b0;
         Z <= 1'b0;
         N <= 1'b0;
         V <= 1'b0;
         dz <= 1'b0;
         err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               a_r <= A;
               b_zero <= B == '0;
               state <= op == OP_MUL ? S_MUL : op == OP_DIV ? S_DIV : S_DONE;
               if (!is_iter(op)) begin
                  result <= s_res;
                  result_hi <= '0;
                  cout <= s_cout;
                  Z <= s_res == '0;
                  N <= s_res[WIDTH-1];
                  V <= s_v;
                  dz <= 1'b0;
                  err <= op[3] & op[2];
               end
            end
            S_MUL, S_DIV: if (m_done) begin
               state <= S_DONE;
               result <= q_lo;
               result_hi <= q_hi;
               cout <= 1'b0;
               Z <= q_lo == '0;
               N <= q_lo[WIDTH-1];
               V <= state == S_MUL && m_hi != {WIDTH{m_lo[WIDTH-1]}};
               dz <= state == S_DIV && b_zero;
               err <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  in  1  request; accepted only when busy=0.
REQ-005 SHALL have port op  in  4  operation code, sampled with start.
REQ-006 SHALL have ports A, B  in  WIDTH  signed operands, sampled with start.
REQ-007 SHALL have port cin  in  1  carry/borrow-in for ADD/SUB, sampled with start.
REQ-008 SHALL have port busy  out  1  high from accept until done cycle inclusive.
REQ-009 SHALL have port done  out  1  one-cycle pulse; outputs valid in that cycle.
REQ-010 SHALL have ports result, result_hi  out  WIDTH  low word; high word (MUL product high, DIV remainder, else 0).
REQ-011 SHALL have ports cout, Z, N, V, dz, err  out  1 each  carry, zero, negative, overflow, divide-by-zero, illegal-op.

Function
REQ-012 Op codes SHALL be: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 XOR, 0111 SHL, 1000 SHR, 1001 ROL, 1010 ROR, 1011 ASR (new); 1100-1111 illegal.
REQ-013 FSM states SHALL be IDLE, MUL, DIV, DONE; IDLE->DONE for single-cycle ops, IDLE->MUL/DIV for MUL/DIV, MUL/DIV->DONE after WIDTH iterations, DONE->IDLE unconditionally.
REQ-014 Latency SHALL be: single-cycle ops, done high in the cycle after the accepting edge; MUL/DIV, done high exactly WIDTH+1 cycles after the accepting edge.
REQ-015 start while busy=1 (including in DONE) SHALL be ignored, not queued.
REQ-016 Operands SHALL be latched at accept; input changes while busy SHALL not affect the result.
REQ-017 ADD: result=A+B+cin, cout=unsigned carry-out, V=signed overflow.
REQ-018 SUB: result=A-B-cin computed as A+~B+!cin; cout=1 means no borrow; V=signed overflow.
REQ-019 MUL: iterative shift-add, signed 2*WIDTH product; {result_hi,result}=A*B; V=1 when the product does not fit in WIDTH signed bits.
REQ-020 DIV: iterative restoring on magnitudes; quotient truncates toward zero; remainder carries the sign of A.
REQ-021 DIV with B=0: no iteration error; result all-ones, result_hi=A, dz=1, still WIDTH+1 latency.
REQ-022 SHL/SHR/ROL/ROR: cout=bit shifted/rotated out; ASR: sign-fill shift right by 1, cout=A[0].
REQ-023 Logic ops and shifts/rotates SHALL clear V; cout=0 for logic ops.
REQ-024 Z=(result==0), N=result[WIDTH-1] for every legal op.
REQ-025 Illegal op: result=0, result_hi=0, Z=1, err=1, latency 1.
REQ-026 result, result_hi and all flags SHALL be registered, updated only on entry to DONE, and held until the next entry to DONE.

Reset
REQ-027 rst SHALL force IDLE and zero busy, done, result, result_hi, cout, Z, N, V, dz, err on the same edge.
REQ-028 rst mid-MUL/DIV SHALL abort the operation; no done pulse for it; start in the cycle after rst release is accepted.
REQ-029 rst SHALL dominate start on the same edge.

Structure
REQ-030 Package alu_pkg SHALL hold op-code constants, the FSM state typedef, and the op-class helper (single-cycle vs iterative).
REQ-031 The iterative MUL/DIV datapath SHALL be one sub-module alu_muldiv_seq (load, step, WIDTH-count, done), instanced once.

Verification (WIDTH=8)
REQ-032 ADD A=100,B=50,cin=0 -> done next cycle, result=0x96, V=1, N=1, cout=0.
REQ-033 SUB A=5,B=5,cin=0 -> result=0, Z=1, cout=1, V=0.
REQ-034 MUL A=-7,B=20 -> done at cycle 9, result=0x74, result_hi=0xFF, V=1; start pulse at cycle 3 ignored.
REQ-035 DIV A=-100,B=7 -> result=0xF2 (-14), result_hi=0xFE (-2), dz=0; DIV A=9,B=0 -> result=0xFF, result_hi=0x09, dz=1.
REQ-036 rst asserted 4 cycles into MUL -> all outputs 0 and busy=0 next cycle, no done; following ASR A=0x81 -> result=0xC0, cout=1.
REQ-037 op=1101 -> result=0, Z=1, err=1, done next cycle.
